// File: rtl/psg_pkg.sv
// Shared types and helpers for the multi-chip PSG front end.
package psg_pkg;

  typedef enum logic [1:0] {
    SM_ABC  = 2'b00,
    SM_ACB  = 2'b01,
    SM_MONO = 2'b10
  } stereo_mode_t;

  typedef enum logic [1:0] {
    MIX_IDLE,
    MIX_ACCUM,
    MIX_DONE
  } mix_state_t;

  typedef struct packed {
    logic [8:0] l;
    logic [8:0] r;
  } lr_t;

  localparam logic [5:0] PSG_SEL_PREFIX = 6'b111111;

  // Per-chip left/right contribution; mode 2'b11 falls back to ABC.
  function automatic lr_t psg_contrib(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [1:0] mode);
    lr_t        res;
    logic [8:0] bc;
    bc = {1'b0, b} + {1'b0, c};
    case (mode)
      SM_ACB: begin
        res.l = {1'b0, a} + {1'b0, c};
        res.r = bc;
      end
      SM_MONO: begin
        res.l = {1'b0, a} + {1'b0, bc[8:1]};
        res.r = res.l;
      end
      default: begin
        res.l = {1'b0, a} + {1'b0, b};
        res.r = {1'b0, c} + {1'b0, b};
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/multi_psg_if.sv
// PSG CPU-side bus: BDIR/BC1 control, write data, read data and output enable.
interface multi_psg_if;
  logic       bdir;
  logic       bc1;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe_n;

  modport master (output bdir, output bc1, output din, input dout, input oe_n);
  modport slave  (input bdir, input bc1, input din, output dout, output oe_n);
endinterface

// File: rtl/ay_3_8192.sv
// Register-file level AY core: BDIR/BC2/BC1 bus decode, 16 registers, and
// channel amplitude levels refreshed on the chip clock enable.
// Port A outputs exist only when MULTI_PSG_MIDI_EN is defined.
module ay_3_8192 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clken,
  input  logic       a8,
  input  logic       bdir,
  input  logic       bc1,
  input  logic       bc2,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe_n,
  output logic [7:0] ch_a,
  output logic [7:0] ch_b,
  output logic [7:0] ch_c
`ifdef MULTI_PSG_MIDI_EN
  ,
  output logic [7:0] port_a,
  output logic       port_a_oe_n
`endif
);

  logic [7:0] regs [16];
  logic [3:0] addr;
  logic [2:0] bus_op;

  assign bus_op = {bdir, bc2, bc1};

  // Address latch (upper nibble must be zero), register writes, level refresh.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
      addr <= '0;
      ch_a <= '0;
      ch_b <= '0;
      ch_c <= '0;
    end else begin
      if (a8 && bus_op == 3'b111 && din[7:4] == 4'h0) addr <= din[3:0];
      if (a8 && bus_op == 3'b110) regs[addr] <= din;
      if (clken) begin
        ch_a <= regs[8];
        ch_b <= regs[9];
        ch_c <= regs[10];
      end
    end
  end

  // Read path drives only while this chip is selected and in a read cycle.
  always_comb begin
    dout = regs[addr];
    oe_n = !(a8 && bus_op == 3'b011);
  end

`ifdef MULTI_PSG_MIDI_EN
  assign port_a      = regs[14];
  assign port_a_oe_n = ~regs[7][6];
`endif

endmodule

// File: rtl/psg_stereo_mixer.sv
// Sequential stereo mixer: walks one chip per clock, accumulating L/R,
// then latches the sample and strobes valid.
module psg_stereo_mixer
  import psg_pkg::*;
#(
  parameter int unsigned NUM_CHIPS = 3,
  parameter int unsigned OUT_W     = 9 + $clog2(NUM_CHIPS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [24*NUM_CHIPS-1:0] ch_bus,
  input  logic [NUM_CHIPS-1:0]   chip_en,
  input  logic [1:0]             stereo_mode,
  output logic [OUT_W-1:0]       left,
  output logic [OUT_W-1:0]       right,
  output logic                   valid
);

  mix_state_t       state;
  logic [1:0]       idx;
  logic [OUT_W-1:0] acc_l;
  logic [OUT_W-1:0] acc_r;
  logic [23:0]      cur_ch;
  logic             cur_en;
  lr_t              cur;

  // Contribution of the chip currently addressed by idx; disabled chips add 0.
  always_comb begin
    cur_ch = '0;
    cur_en = 1'b0;
    for (int unsigned i = 0; i < NUM_CHIPS; i++) begin
      if (idx == i[1:0]) begin
        cur_ch = ch_bus[24*i +: 24];
        cur_en = chip_en[i];
      end
    end
    cur = psg_contrib(cur_ch[7:0], cur_ch[15:8], cur_ch[23:16], stereo_mode);
    if (!cur_en) cur = '0;
  end

  // Mixer FSM with registered sample outputs and valid strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= MIX_IDLE;
      idx   <= '0;
      acc_l <= '0;
      acc_r <= '0;
      left  <= '0;
      right <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        MIX_IDLE: begin
          if (start) begin
            acc_l <= '0;
            acc_r <= '0;
            idx   <= '0;
            state <= MIX_ACCUM;
          end
        end
        MIX_ACCUM: begin
          acc_l <= acc_l + OUT_W'(cur.l);
          acc_r <= acc_r + OUT_W'(cur.r);
          idx   <= idx + 2'd1;
          if (idx == 2'(NUM_CHIPS - 1)) state <= MIX_DONE;
        end
        MIX_DONE: begin
          left  <= acc_l;
          right <= acc_r;
          valid <= 1'b1;
          state <= MIX_IDLE;
        end
        default: state <= MIX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/multi_psg.sv
// Multi-chip PSG front end: escape-code chip select, bus routing to
// NUM_CHIPS AY cores, and the stereo mixer.
// Optional feature macro: MULTI_PSG_MIDI_EN (adds registered midi_out).
module multi_psg
  import psg_pkg::*;
#(
  parameter int unsigned NUM_CHIPS = 3,
  parameter int unsigned OUT_W     = 9 + $clog2(NUM_CHIPS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clk175en,
  input  logic [NUM_CHIPS-1:0] chip_en,
  input  logic [1:0]           stereo_mode,
  multi_psg_if.slave           bus,
  output logic [OUT_W-1:0]     audio_left,
  output logic [OUT_W-1:0]     audio_right,
  output logic                 audio_valid
`ifdef MULTI_PSG_MIDI_EN
  ,
  output logic                 midi_out
`endif
);

  logic [1:0]             sel;
  logic [1:0]             cand;
  logic [3:0]             en_ext;
  logic [3:0][7:0]        dout_arr;
  logic [3:0]             oe_n_arr;
  logic [24*NUM_CHIPS-1:0] ch_bus;
`ifdef MULTI_PSG_MIDI_EN
  logic [3:0][7:0]        pa_arr;
  logic [3:0]             pa_oe_n_arr;
`endif

  // Enables padded to four slots; slots beyond NUM_CHIPS read as disabled,
  // which also covers the index < NUM_CHIPS acceptance check.
  always_comb begin
    en_ext = '0;
    en_ext[NUM_CHIPS-1:0] = chip_en;
  end

  assign cand = ~bus.din[1:0];

  // Chip select register, updated by the FF..FC escape on an address latch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel <= '0;
    end else if (bus.bdir && bus.bc1 && bus.din[7:2] == PSG_SEL_PREFIX && en_ext[cand]) begin
      sel <= cand;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_chip
    if (i < NUM_CHIPS) begin : g_on
      ay_3_8192 u_ay (
        .clk     (clk),
        .reset_n (reset_n),
        .clken   (chip_en[i] & clk175en),
        .a8      (sel == 2'(i)),
        .bdir    (bus.bdir),
        .bc1     (bus.bc1),
        .bc2     (1'b1),
        .din     (bus.din),
        .dout    (dout_arr[i]),
        .oe_n    (oe_n_arr[i]),
        .ch_a    (ch_bus[24*i +: 8]),
        .ch_b    (ch_bus[24*i+8 +: 8]),
        .ch_c    (ch_bus[24*i+16 +: 8])
`ifdef MULTI_PSG_MIDI_EN
        ,
        .port_a      (pa_arr[i]),
        .port_a_oe_n (pa_oe_n_arr[i])
`endif
      );
    end else begin : g_off
      assign dout_arr[i] = '0;
      assign oe_n_arr[i] = 1'b1;
`ifdef MULTI_PSG_MIDI_EN
      assign pa_arr[i]      = '0;
      assign pa_oe_n_arr[i] = 1'b1;
`endif
    end
  end

  assign bus.dout = dout_arr[sel];
  assign bus.oe_n = en_ext[sel] ? oe_n_arr[sel] : 1'b1;

  psg_stereo_mixer #(
    .NUM_CHIPS (NUM_CHIPS),
    .OUT_W     (OUT_W)
  ) u_mixer (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (clk175en),
    .ch_bus      (ch_bus),
    .chip_en     (chip_en),
    .stereo_mode (stereo_mode),
    .left        (audio_left),
    .right       (audio_right),
    .valid       (audio_valid)
  );

`ifdef MULTI_PSG_MIDI_EN
  // MIDI line follows port A bit 2 of the selected chip when it is driving.
  always_ff @(posedge clk) begin
    if (!reset_n) midi_out <= 1'b0;
    else          midi_out <= en_ext[sel] & ~pa_oe_n_arr[sel] & pa_arr[sel][2];
  end
`endif

endmodule
